// File: rtl/seq_intersect_ctrl.sv
// seq_intersect_ctrl: round-robin arbiter driving one a/b/c "intersect" burst per grant (optional abort: `SEQ_ABORT_EN).
// Latency: 1 cycle from req to gnt/a/b; burst is B_RUN+1 cycles, then GAP idle cycles; every output is registered.
// Backpressure: none; requesters hold req until done, a started burst never stalls (it can only be aborted).
module seq_intersect_ctrl #(
    parameter int B_RUN = 3,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
`ifdef SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic [CNT_W-1:0] seq_cnt
);

    localparam int PH_MAX = (B_RUN > GAP) ? B_RUN : GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        B_PH   = 2'd1,
        C_PH   = 2'd2,
        GAP_PH = 2'd3
    } state_t;

    state_t          state, nxt_state;
    logic [PH_W-1:0] ph, nxt_ph;
    logic [1:0]      nxt_gnt;
    logic            last_gnt, nxt_last;
    logic            sel;
    logic            do_done;
    logic            abort_hit;

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Next-state, phase count and arbitration; done/count fire only on a C_PH exit that was not aborted.
    always_comb begin
        nxt_state = state;
        nxt_ph    = ph;
        nxt_gnt   = gnt;
        nxt_last  = last_gnt;
        sel       = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    // On a tie the requester that did not win last time goes first.
                    sel       = (req == 2'b11) ? ~last_gnt : req[1];
                    nxt_state = B_PH;
                    nxt_ph    = '0;
                    nxt_gnt   = sel ? 2'b10 : 2'b01;
                    nxt_last  = sel;
                end
            end
            B_PH: begin
                if (abort_hit) begin
                    nxt_state = GAP_PH;
                    nxt_ph    = '0;
                    nxt_gnt   = 2'b00;
                end else if (ph == PH_W'(B_RUN - 1)) begin
                    nxt_state = C_PH;
                    nxt_ph    = '0;
                end else begin
                    nxt_ph = ph + PH_W'(1);
                end
            end
            C_PH: begin
                nxt_state = GAP_PH;
                nxt_ph    = '0;
                nxt_gnt   = 2'b00;
                do_done   = ~abort_hit;
            end
            GAP_PH: begin
                if (ph == PH_W'(GAP - 1)) begin
                    nxt_state = IDLE;
                    nxt_ph    = '0;
                end else begin
                    nxt_ph = ph + PH_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_ph    = '0;
                nxt_gnt   = 2'b00;
            end
        endcase
    end

    // State, pointer and registered outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ph       <= '0;
            last_gnt <= 1'b1;
            gnt      <= 2'b00;
            done     <= 2'b00;
            a        <= 1'b0;
            b        <= 1'b0;
            c        <= 1'b0;
            busy     <= 1'b0;
            seq_cnt  <= '0;
        end else begin
            state    <= nxt_state;
            ph       <= nxt_ph;
            last_gnt <= nxt_last;
            gnt      <= nxt_gnt;
            done     <= do_done ? gnt : 2'b00;
            a        <= (nxt_state == B_PH) || (nxt_state == C_PH);
            b        <= (nxt_state == B_PH);
            c        <= (nxt_state == C_PH);
            busy     <= (nxt_state != IDLE);
            if (do_done) begin
                seq_cnt <= seq_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_intersect_ctrl.sv
// tb_seq_intersect_ctrl: directed scenarios plus random req/reset (and abort) against a burst-timeline model.
// Latency: model predicts each cycle's outputs from the offset since burst start.
// Backpressure: n/a.
module tb_seq_intersect_ctrl;

    localparam int B_RUN = 3;
    localparam int GAP   = 2;
    localparam int CNT_W = 8;
`ifdef SEQ_ABORT_EN
    localparam bit AB_EN = 1'b1;
`else
    localparam bit AB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = 2'b00;
    logic             abort_i = 1'b0;
    logic [1:0]       gnt, done;
    logic             a, b, c, busy;
    logic [CNT_W-1:0] seq_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: burst timeline. Offset 0..B_RUN-1 = b, B_RUN = c, then GAP idle cycles.
    bit m_act = 0;
    int m_off = 0;
    int m_g   = 0;
    int m_last = 1;
    int m_cnt = 0;
    bit m_abt = 0;

    seq_intersect_ctrl #(.B_RUN(B_RUN), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
`ifdef SEQ_ABORT_EN
        .abort   (abort_i),
`endif
        .gnt     (gnt),
        .done    (done),
        .a       (a),
        .b       (b),
        .c       (c),
        .busy    (busy),
        .seq_cnt (seq_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic m_reset();
        m_act = 0; m_off = 0; m_g = 0; m_last = 1; m_cnt = 0; m_abt = 0;
    endtask

    task automatic m_step(input logic [1:0] r, input logic ab);
        if (m_act) begin
            if (AB_EN && ab && m_off <= B_RUN) begin
                m_off = B_RUN + 1;
                m_abt = 1;
            end else begin
                m_off++;
                if (m_off == B_RUN + 1 && !m_abt) m_cnt++;
                if (m_off == B_RUN + GAP + 1) m_act = 0;
            end
        end else if (r != 2'b00) begin
            if (r == 2'b11) m_g = (m_last == 0) ? 1 : 0;
            else            m_g = r[1] ? 1 : 0;
            m_last = m_g;
            m_act  = 1;
            m_off  = 0;
            m_abt  = 0;
        end
    endtask

    task automatic compare();
        logic [1:0] oh;
        oh = (m_g == 1) ? 2'b10 : 2'b01;
        chk("a",    a,    m_act && m_off <= B_RUN);
        chk("b",    b,    m_act && m_off <  B_RUN);
        chk("c",    c,    m_act && m_off == B_RUN);
        chk("gnt",  gnt,  (m_act && m_off <= B_RUN) ? oh : 2'b00);
        chk("done", done, (m_act && m_off == B_RUN + 1 && !m_abt) ? oh : 2'b00);
        chk("busy", busy, m_act);
        chk("seq_cnt", seq_cnt, m_cnt % (1 << CNT_W));
    endtask

    // One clock: inputs change at the negedge, DUT samples at posedge, outputs checked at next negedge.
    task automatic step(input logic [1:0] r, input logic ab, input logic rn);
        req     = r;
        abort_i = ab;
        if (!rn) begin
            rst_n = 1'b0;
            #1;
            chk("rst_abc",  {a, b, c}, 3'b000);
            chk("rst_gnt",  gnt, 2'b00);
            chk("rst_done", done, 2'b00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_cnt",  seq_cnt, 0);
            m_reset();
        end else begin
            rst_n = 1'b1;
        end
        @(posedge clk);
        if (rn) m_step(r, ab);
        @(negedge clk);
        compare();
        cyc++;
    endtask

    task automatic do_reset();
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g, prev_g;
        int last_start;
        bit seen;

        // Scenario: single pulsed request.
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            step((k == 1) ? 2'b01 : 2'b00, 1'b0, 1'b1);
            chk("t1_ab",   {a, b}, (k <= 3) ? 2'b11 : ((k == 4) ? 2'b10 : 2'b00));
            chk("t1_c",    c, k == 4);
            chk("t1_done", done, (k == 5) ? 2'b01 : 2'b00);
            chk("t1_cnt",  seq_cnt, (k >= 5) ? 1 : 0);
            chk("t1_busy", busy, k < 7);
        end

        // Scenario: both requesting, grants alternate with a 7-cycle period.
        do_reset();
        exp_g = 2'b01; prev_g = 2'b00; last_start = 0; seen = 0;
        for (int k = 1; k <= 28; k++) begin
            step(2'b11, 1'b0, 1'b1);
            if (gnt != 2'b00 && prev_g == 2'b00) begin
                chk("t2_gnt", gnt, exp_g);
                if (seen) chk("t2_period", cyc - last_start, 7);
                seen = 1; last_start = cyc; exp_g = ~exp_g;
            end
            prev_g = gnt;
        end
        chk("t2_bursts", last_start, 22);

        // Scenario: reset during the second B_PH cycle, then requester 1 alone.
        do_reset();
        step(2'b01, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b1);
        chk("t3_gnt", gnt, 2'b10);
        chk("t3_cnt", seq_cnt, 0);
        for (int k = 0; k < 8; k++) step(2'b00, 1'b0, 1'b1);

        // Scenario: counter wrap after 256 bursts.
        do_reset();
        for (int k = 1; k <= 1789; k++) step(2'b01, 1'b0, 1'b1);
        chk("t4_cnt255", seq_cnt, 255);
        step(2'b01, 1'b0, 1'b1);
        chk("t4_wrap", seq_cnt, 0);
        chk("t4_done", done, 2'b01);
        for (int k = 0; k < 8; k++) step(2'b00, 1'b0, 1'b1);

        if (AB_EN) begin
            // Scenario: abort in the second B_PH cycle.
            do_reset();
            step(2'b01, 1'b0, 1'b1);
            step(2'b01, 1'b0, 1'b1);
            step(2'b01, 1'b1, 1'b1);
            chk("t5_abc", {a, b, c, gnt}, 5'b0);
            step(2'b01, 1'b0, 1'b1);
            chk("t5_done", done, 2'b00);
            chk("t5_cnt", seq_cnt, 0);
            step(2'b01, 1'b0, 1'b1);
            chk("t5_idle", busy, 1'b0);
            step(2'b01, 1'b0, 1'b1);
            chk("t5_restart", gnt, 2'b01);
            for (int k = 0; k < 8; k++) step(2'b00, 1'b0, 1'b1);
        end

        // Random traffic with occasional reset and abort.
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            step(2'($urandom_range(0, 3)),
                 AB_EN && ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 99) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
